// File: rtl/n_bit_muldiv_unit.sv
// n_bit_muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit. One operation is accepted
// through a valid/ready handshake, iterated one bit per cycle (shift-add
// multiply, restoring divide), sign-corrected in a final cycle and presented
// as a registered result through a second valid/ready handshake.
//
// Parameters:
//   N      operand/result width (8..64, even)
//   CNT_W  iteration counter width, derived from N
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operation request
//   in_ready     unit can accept a request (IDLE)
//   op           RISC-V funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b         rs1 / rs2 operands
//   out_valid    result available (DONE)
//   out_ready    consumer takes the result
//   result       registered result
//   div_by_zero  registered flag: divide/remainder with b == 0
//   busy         unit is iterating (BUSY)
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN  divide-by-zero, signed divide overflow and multiply
//                        by zero skip the iterations and finish in the
//                        cycle after accept.

module n_bit_muldiv_unit #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero,
    output logic         busy
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [N-1:0]     ZERO_N   = {N{1'b0}};
    localparam logic [N-1:0]     ONES_N   = {N{1'b1}};
    localparam logic [N-1:0]     MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [2*N-1:0]   ZERO_2N  = {(2*N){1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,       state_d;
    logic [2:0]       op_q,          op_d;
    logic [N-1:0]     a_q,           a_d;
    logic [N-1:0]     mag_a_q,       mag_a_d;
    logic [N-1:0]     mag_b_q,       mag_b_d;
    logic             neg_res_q,     neg_res_d;
    logic             neg_rem_q,     neg_rem_d;
    logic             bz_flag_q,     bz_flag_d;
    logic             ovf_flag_q,    ovf_flag_d;
    logic [2*N-1:0]   acc_q,         acc_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [N-1:0]     result_q,      result_d;
    logic             div_by_zero_q, div_by_zero_d;

    // Accept-time decode
    logic         a_neg_s;
    logic         b_neg_s;
    logic [N-1:0] mag_a_in_s;
    logic [N-1:0] mag_b_in_s;
    logic         bz_in_s;
    logic         ovf_in_s;
    logic         early_s;

    // Iteration datapath
    logic [N:0]   mul_sum_s;
    logic [N:0]   div_shift_s;
    logic [N:0]   div_diff_s;
    logic [N-1:0] rem_new_s;

    // Final sign correction and output selection
    logic [2*N-1:0] prod_fix_s;
    logic [N-1:0]   quo_fix_s;
    logic [N-1:0]   rem_fix_s;
    logic [N-1:0]   sel_s;

    // Operand signedness, magnitudes and special-case detection for a new request
    always_comb begin
        // MUL is treated as unsigned: its low half does not depend on the signs.
        a_neg_s = a[N-1] && ((op == OP_MULH) || (op == OP_MULHSU) ||
                             (op == OP_DIV)  || (op == OP_REM));
        b_neg_s = b[N-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        mag_a_in_s = a_neg_s ? (ZERO_N - a) : a;
        mag_b_in_s = b_neg_s ? (ZERO_N - b) : b;
        bz_in_s  = op[2] && (b == ZERO_N);
        ovf_in_s = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == ONES_N);
`ifdef MULDIV_EARLY_OUT_EN
        early_s = bz_in_s || ovf_in_s || (!op[2] && ((a == ZERO_N) || (b == ZERO_N)));
`else
        early_s = 1'b0;
`endif
    end

    // One iteration step for both the multiplier and the divider
    always_comb begin
        // Multiply: right-shifting accumulate, multiplier consumed LSB first.
        mul_sum_s = {1'b0, acc_q[2*N-1:N]} + (mag_b_q[0] ? {1'b0, mag_a_q} : {1'b0, ZERO_N});
        // Divide: remainder lives in acc[2N-1:N], quotient bits shift into acc[N-1:0],
        // dividend bits are fed MSB first from mag_a.
        div_shift_s = {acc_q[2*N-1:N], mag_a_q[N-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_b_q};
        // A borrow out of bit N means the trial subtraction went negative: restore.
        if (div_diff_s[N]) begin
            rem_new_s = div_shift_s[N-1:0];
        end else begin
            rem_new_s = div_diff_s[N-1:0];
        end
    end

    // Two's-complement sign correction and result selection
    always_comb begin
        prod_fix_s = neg_res_q ? (ZERO_2N - acc_q) : acc_q;
        quo_fix_s  = neg_res_q ? (ZERO_N - acc_q[N-1:0]) : acc_q[N-1:0];
        // Remainder takes the sign of the dividend.
        rem_fix_s  = neg_rem_q ? (ZERO_N - acc_q[2*N-1:N]) : acc_q[2*N-1:N];
        case (op_q)
            OP_MUL:                         sel_s = prod_fix_s[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   sel_s = prod_fix_s[2*N-1:N];
            OP_DIV, OP_DIVU: begin
                if (bz_flag_q) begin
                    sel_s = ONES_N;
                end else if (ovf_flag_q) begin
                    sel_s = a_q;
                end else begin
                    sel_s = quo_fix_s;
                end
            end
            OP_REM, OP_REMU: begin
                if (bz_flag_q) begin
                    sel_s = a_q;
                end else if (ovf_flag_q) begin
                    sel_s = ZERO_N;
                end else begin
                    sel_s = rem_fix_s;
                end
            end
            default:                        sel_s = ZERO_N;
        endcase
    end

    // Next-state and next-register computation for the IDLE/BUSY/DONE machine
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        bz_flag_d     = bz_flag_q;
        ovf_flag_d    = ovf_flag_q;
        acc_d         = acc_q;
        count_d       = count_q;
        result_d      = result_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d       = op;
                    a_d        = a;
                    mag_a_d    = mag_a_in_s;
                    mag_b_d    = mag_b_in_s;
                    neg_res_d  = a_neg_s ^ b_neg_s;
                    neg_rem_d  = a_neg_s;
                    bz_flag_d  = bz_in_s;
                    ovf_flag_d = ovf_in_s;
                    acc_d      = ZERO_2N;
                    // Early-out jumps straight to the finishing cycle; the cleared
                    // accumulator already holds the zero product.
                    count_d    = early_s ? CNT_LAST : CNT_ZERO;
                    state_d    = S_BUSY;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_BUSY: begin
                if (count_q != CNT_LAST) begin
                    if (op_q[2] == 1'b0) begin
                        acc_d   = {mul_sum_s, acc_q[N-1:1]};
                        mag_b_d = mag_b_q >> 1;
                    end else begin
                        acc_d   = {rem_new_s, acc_q[N-2:0], ~div_diff_s[N]};
                        mag_a_d = mag_a_q << 1;
                    end
                    count_d = count_q + CNT_ONE;
                end else begin
                    result_d      = sel_s;
                    div_by_zero_d = bz_flag_q;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= 3'b000;
            a_q           <= ZERO_N;
            mag_a_q       <= ZERO_N;
            mag_b_q       <= ZERO_N;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            bz_flag_q     <= 1'b0;
            ovf_flag_q    <= 1'b0;
            acc_q         <= ZERO_2N;
            count_q       <= CNT_ZERO;
            result_q      <= ZERO_N;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            mag_a_q       <= mag_a_d;
            mag_b_q       <= mag_b_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            bz_flag_q     <= bz_flag_d;
            ovf_flag_q    <= ovf_flag_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            result_q      <= result_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Handshake and status outputs decode the state register only
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_BUSY);
    assign result      = result_q;
    assign div_by_zero = div_by_zero_q;

endmodule
